imem_stream_loader: RTL and testbench

- Parametrised successor to the fixed, testbench-driven instruction-memory preload sequence.
- Accepts a program as a valid/ready word stream, writes it into instruction memory at a programmable base address and length, then asserts the datapath start.
- Sits between the host/boot side and Multicycle_Datapath's I_MEM write port and start input.
- Adds range checking, auto/manual start modes, abort and session status.

---
 rtl/imem_loader_pkg.sv | 16 +
 rtl/imem_stream_loader.sv | 146 ++++++++++++++
 tb/tb_imem_stream_loader.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and default widths for the instruction-memory stream loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StGap,
        StArmed,
        StRun
    } state_e;

    localparam int unsigned DefDataW = 32;
    localparam int unsigned DefAddrW = 16;
    localparam int unsigned DefDepth = 64;

endpackage

// File: rtl/imem_stream_loader.sv
// Streams a program into instruction memory at a checked base/length, then
// raises the datapath start either automatically or on a run request.
module imem_stream_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned DATA_W     = DefDataW,
    parameter int unsigned ADDR_W     = DefAddrW,
    parameter int unsigned DEPTH      = DefDepth,
    parameter bit          AUTO_START = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_req,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              run_req,
    input  logic              abort,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] word_cnt
);

    localparam int unsigned         SumW   = ADDR_W + 1;
    localparam logic [SumW-1:0]     DepthS = SumW'(DEPTH);

    state_e state_q, state_d;

    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [SumW-1:0] range_end;
    logic            range_ok;
    logic            load_go;
    logic            hs;
    logic            last_hs;

    // One extra bit keeps base+length from wrapping back into range.
    assign range_end = {1'b0, base_addr} + {1'b0, length};
    assign range_ok  = (length != '0) && (range_end <= DepthS);
    assign load_go   = (state_q == StIdle) && load_req && !abort;
    // A word offered in the abort cycle is dropped, not written.
    assign hs        = in_valid && in_ready && !abort;
    assign last_hs   = hs && ((cnt_q + ADDR_W'(1)) == len_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle:  if (load_req && range_ok) state_d = StLoad;
                StLoad:  if (last_hs) state_d = StGap;
                StGap:   state_d = AUTO_START ? StRun : StArmed;
                StArmed: if (run_req) state_d = StRun;
                StRun:   state_d = StRun;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        in_ready = (state_q == StLoad);
        busy     = (state_q == StLoad) || (state_q == StGap);
        start    = (state_q == StRun);
    end

    always_comb begin
        base_d  = base_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        err_d   = err_q;
        if (load_go) begin
            if (range_ok) begin
                base_d = base_addr;
                len_d  = length;
                cnt_d  = '0;
                err_d  = 1'b0;
            end else begin
                err_d  = 1'b1;
            end
        end
        if (hs) begin
            we_d    = 1'b1;
            addr_d  = base_q + cnt_q;
            wdata_d = in_data;
            cnt_d   = cnt_q + ADDR_W'(1);
            done_d  = last_hs;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            base_q  <= base_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign done       = done_q;
    assign err        = err_q;
    assign word_cnt   = cnt_q;

endmodule

// File: tb/tb_imem_stream_loader.sv
// Drives an auto-start and a manual-start loader with the same stream and
// checks every cycle against expectations derived from the session rules.
module tb_imem_stream_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_req;
    logic [15:0] base_addr;
    logic [15:0] length;
    logic        in_valid;
    logic [31:0] in_data;
    logic        run_req;
    logic        abort;

    logic        a_in_ready, a_we, a_start, a_busy, a_done, a_err;
    logic [15:0] a_addr, a_word_cnt;
    logic [31:0] a_wdata;
    logic        m_in_ready, m_we, m_start, m_busy, m_done, m_err;
    logic [15:0] m_addr, m_word_cnt;
    logic [31:0] m_wdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    imem_stream_loader #(
        .DATA_W(32), .ADDR_W(16), .DEPTH(64), .AUTO_START(1'b1)
    ) dut_a (
        .clk(clk), .rst(rst), .load_req(load_req), .base_addr(base_addr),
        .length(length), .in_valid(in_valid), .in_data(in_data),
        .in_ready(a_in_ready), .run_req(run_req), .abort(abort),
        .imem_we(a_we), .imem_addr(a_addr), .imem_wdata(a_wdata),
        .start(a_start), .busy(a_busy), .done(a_done), .err(a_err),
        .word_cnt(a_word_cnt)
    );

    imem_stream_loader #(
        .DATA_W(32), .ADDR_W(16), .DEPTH(64), .AUTO_START(1'b0)
    ) dut_m (
        .clk(clk), .rst(rst), .load_req(load_req), .base_addr(base_addr),
        .length(length), .in_valid(in_valid), .in_data(in_data),
        .in_ready(m_in_ready), .run_req(run_req), .abort(abort),
        .imem_we(m_we), .imem_addr(m_addr), .imem_wdata(m_wdata),
        .start(m_start), .busy(m_busy), .done(m_done), .err(m_err),
        .word_cnt(m_word_cnt)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_a_we"}, a_we, 0);
        check_eq({tag, "_m_we"}, m_we, 0);
        check_eq({tag, "_a_ready"}, a_in_ready, 0);
        check_eq({tag, "_m_ready"}, m_in_ready, 0);
        check_eq({tag, "_a_busy"}, a_busy, 0);
        check_eq({tag, "_a_start"}, a_start, 0);
        check_eq({tag, "_m_start"}, m_start, 0);
        check_eq({tag, "_a_done"}, a_done, 0);
    endtask

    task automatic bad_load(input logic [15:0] base, input logic [15:0] len);
        load_req = 1'b1; base_addr = base; length = len;
        tick();
        load_req = 1'b0;
        check_eq("bad_a_err", a_err, 1);
        check_eq("bad_m_err", m_err, 1);
        check_quiet("bad");
        in_valid = 1'b1; in_data = $urandom;
        tick();
        in_valid = 1'b0;
        check_eq("bad_err_sticky", a_err, 1);
        check_quiet("bad_hold");
    endtask

    // mode: 0 random valid, 1 continuous, 2 fixed 1,0,1,1,0,1 pattern
    task automatic session(input logic [15:0] base, input logic [15:0] len, input int mode,
                           input int abort_at, input int rst_at);
        int          acc;
        int          guard;
        logic        v;
        logic [31:0] d;
        logic [15:0] ea;
        logic [5:0]  pat;
        pat = 6'b101101;
        load_req = 1'b1; base_addr = base; length = len;
        tick();
        load_req = 1'b0;
        check_eq("acc_a_err", a_err, 0);
        check_eq("acc_m_err", m_err, 0);
        check_eq("acc_a_ready", a_in_ready, 1);
        check_eq("acc_m_ready", m_in_ready, 1);
        check_eq("acc_cnt", a_word_cnt, 0);
        acc = 0;
        guard = 0;
        while (acc < int'(len) && guard < 1000) begin
            d = $urandom;
            if (mode == 1) v = 1'b1;
            else if (mode == 2) v = (guard < 6) ? pat[5-guard] : 1'b1;
            else v = ($urandom_range(0, 3) != 0);
            if (abort_at >= 0 && acc == abort_at) begin
                in_valid = 1'b1; in_data = d; abort = 1'b1; run_req = 1'b0;
                tick();
                abort = 1'b0; in_valid = 1'b0;
                check_quiet("abort");
                check_eq("abort_m_done", m_done, 0);
                tick();
                check_quiet("abort_after");
                return;
            end
            if (rst_at >= 0 && acc == rst_at) begin
                in_valid = 1'b1; in_data = d; run_req = 1'b0;
                rst = 1'b1;
                #1;
                check_quiet("rst");
                check_eq("rst_cnt", a_word_cnt, 0);
                check_eq("rst_err", a_err, 0);
                tick();
                rst = 1'b0; in_valid = 1'b0;
                tick();
                check_quiet("rst_after");
                return;
            end
            run_req = 1'($urandom_range(0, 1));
            in_valid = v; in_data = d;
            tick();
            ea = base + 16'(acc);
            check_eq("a_we", a_we, v);
            check_eq("m_we", m_we, v);
            if (v) begin
                check_eq("a_addr", a_addr, ea);
                check_eq("a_wdata", a_wdata, d);
                check_eq("m_addr", m_addr, ea);
                check_eq("m_wdata", m_wdata, d);
                acc++;
            end
            check_eq("word_cnt", a_word_cnt, acc);
            check_eq("a_done", a_done, v && acc == int'(len));
            check_eq("m_done", m_done, v && acc == int'(len));
            check_eq("a_ready", a_in_ready, acc < int'(len));
            check_eq("a_busy", a_busy, 1);
            check_eq("a_start_load", a_start, 0);
            check_eq("m_start_load", m_start, 0);
            guard++;
        end
        in_valid = 1'b0; run_req = 1'b0;
        check_eq("load_timeout", acc, len);
        tick();
        check_eq("gap_a_start", a_start, 1);
        check_eq("gap_m_start", m_start, 0);
        check_eq("gap_a_we", a_we, 0);
        check_eq("gap_a_done", a_done, 0);
        check_eq("gap_a_busy", a_busy, 0);
        check_eq("final_cnt", a_word_cnt, len);
        check_eq("final_m_cnt", m_word_cnt, len);
        tick();
        check_eq("armed_m_start", m_start, 0);
        check_eq("armed_m_ready", m_in_ready, 0);
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        check_eq("run_m_start", m_start, 1);
        check_eq("run_a_start", a_start, 1);
        check_eq("run_a_we", a_we, 0);
        check_eq("run_m_we", m_we, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_quiet("end_abort");
    endtask

    initial begin
        int          len;
        int          base;
        rst = 1'b1; load_req = 1'b0; base_addr = '0; length = '0;
        in_valid = 1'b0; in_data = '0; run_req = 1'b0; abort = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_quiet("reset");
        check_eq("reset_err", a_err, 0);
        check_eq("reset_cnt", a_word_cnt, 0);
        check_eq("reset_addr", a_addr, 0);
        rst = 1'b0;
        tick();

        session(16'd0, 16'd20, 1, -1, -1);
        session(16'd60, 16'd4, 0, -1, -1);
        bad_load(16'd61, 16'd4);
        bad_load(16'd5, 16'd0);
        session(16'd10, 16'd3, 0, -1, -1);
        bad_load(16'hFFF0, 16'h0020);
        session(16'd8, 16'd4, 2, -1, -1);
        session(16'd0, 16'd10, 1, 5, -1);
        session(16'd30, 16'd6, 0, -1, -1);
        session(16'd20, 16'd10, 1, -1, 5);
        session(16'd1, 16'd2, 0, -1, -1);

        for (int i = 0; i < 8; i++) begin
            len  = $urandom_range(1, 12);
            base = $urandom_range(0, 64 - len);
            session(16'(base), 16'(len), 0, -1, -1);
            base = $urandom_range(53, 63);
            bad_load(16'(base), 16'(65 - base + $urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
